// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the decode, fetch and RAM-write stages.
//   - opcode encodings of the four instructions
//   - MMU geometry (page size, hop limit) and address/segment widths
//   - state encoding of the stage-3 RAM writer
package cpu_pkg;

    localparam logic [1:0] OPCODE_JMP     = 2'd0;
    localparam logic [1:0] OPCODE_RAM2REG = 2'd1;
    localparam logic [1:0] OPCODE_REG2RAM = 2'd2;
    localparam logic [1:0] OPCODE_NUM2REG = 2'd3;

    localparam int CPU_ADDR_W    = 10;
    localparam int CPU_SEG_W     = 12;
    localparam int RAM_SIZE      = 1 << CPU_ADDR_W;
    localparam int MMU_PAGE_SIZE = 151;
    localparam int MMU_MAX_HOPS  = 16;

    typedef enum logic [2:0] {
        IDLE,
        XLATE,
        WALK,
        WRITE,
        FAULT
    } writer_state_t;

endpackage

// File: rtl/stage3_ram_writer_mmu_walker.sv
// mmu_walker: one-hop-per-cycle walk along the MMU segment chain.
//   load        : start a walk; first segment is tbl_chain of the start segment
//   active      : a walk cycle; table is read at index cur by the parent
//   seg         : logical segment being searched for
//   tbl_chain   : chain entry of segment cur (combinational table read)
//   tbl_logical : logical page number of segment cur
//   cur         : segment currently examined (parent drives it as table index)
//   hit         : segment cur holds the wanted logical page
//   chain_fault : chain ended (self link) or hop limit reached without a hit
module mmu_walker
    import cpu_pkg::*;
#(
    parameter int SEG_W    = CPU_SEG_W,
    parameter int MAX_HOPS = MMU_MAX_HOPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             active,
    input  logic [SEG_W-1:0] seg,
    input  logic [SEG_W-1:0] tbl_chain,
    input  logic [SEG_W-1:0] tbl_logical,
    output logic [SEG_W-1:0] cur,
    output logic             hit,
    output logic             chain_fault
);

    localparam int HOP_W = $clog2(MAX_HOPS + 1);

    logic [HOP_W-1:0] hops;

    // A hit wins over the end-of-chain / hop-limit tests on the same cycle.
    assign hit         = (tbl_logical == seg);
    assign chain_fault = !hit && ((tbl_chain == cur) || (hops == HOP_W'(MAX_HOPS)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur  <= '0;
            hops <= '0;
        end else if (load) begin
            cur  <= tbl_chain;
            hops <= '0;
        end else if (active && !hit && !chain_fault) begin
            cur  <= tbl_chain;
            hops <= hops + 1'b1;
        end
    end

endmodule

// File: rtl/stage3_ram_writer.sv
// stage3_ram_writer: executes REG2RAM stores. Each byte of the store is
// translated through the MMU (page 0 maps straight to start_segment, other
// pages are found by walking the segment chain) and written through RAM port A.
//   req_valid/req_ready      : request handshake, one store in flight
//   req_addr/req_data/req_two: logical address, value, 2-byte flag
//   start_segment            : physical segment of the process's page 0
//   tbl_index/tbl_chain/tbl_logical : combinational MMU table read
//   ram_ena/ram_wea/ram_addra/ram_dia : RAM port A write
//   busy, done (pulse), fault (pulse) : status
module stage3_ram_writer
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = CPU_ADDR_W,
    parameter int SEG_W     = CPU_SEG_W,
    parameter int PAGE_SIZE = MMU_PAGE_SIZE,
    parameter int MAX_HOPS  = MMU_MAX_HOPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_data,
    input  logic              req_two,
    input  logic [SEG_W-1:0]  start_segment,
    output logic [SEG_W-1:0]  tbl_index,
    input  logic [SEG_W-1:0]  tbl_chain,
    input  logic [SEG_W-1:0]  tbl_logical,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [7:0]        ram_dia,
    output logic              busy,
    output logic              done,
    output logic              fault
);

    localparam int                PHYS_W = SEG_W + ADDR_W;
    localparam logic [ADDR_W-1:0] PAGE_A = ADDR_W'(PAGE_SIZE);

    // Physical address is formed wide enough that no segment index can wrap it.
    function automatic logic [PHYS_W-1:0] to_phys(input logic [SEG_W-1:0]  pseg,
                                                  input logic [ADDR_W-1:0] off);
        return PHYS_W'(pseg) * PHYS_W'(PAGE_SIZE) + PHYS_W'(off);
    endfunction

    function automatic logic in_ram(input logic [PHYS_W-1:0] pa);
        return (pa[PHYS_W-1:ADDR_W] == '0);
    endfunction

    writer_state_t     state, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [SEG_W-1:0]  start_q;
    logic [7:0]        byte_q;
    logic [7:0]        byte2_q;
    logic              two_q;

    logic              accept, ld_write, advance, finish;
    logic              walk_load, walk_active;
    logic [SEG_W-1:0]  walk_cur;
    logic              walk_hit, walk_fault;

    logic [ADDR_W-1:0] seg_a, off_a;
    logic [SEG_W-1:0]  phys_seg;
    logic [PHYS_W-1:0] phys;
    logic              phys_ok;
    logic              done_q;

    assign seg_a    = addr_q / PAGE_A;
    assign off_a    = addr_q % PAGE_A;
    assign phys_seg = (state == WALK) ? walk_cur : start_q;
    assign phys     = to_phys(phys_seg, off_a);
    assign phys_ok  = in_ram(phys);

    mmu_walker #(
        .SEG_W    (SEG_W),
        .MAX_HOPS (MAX_HOPS)
    ) u_walker (
        .clk         (clk),
        .rst         (rst),
        .load        (walk_load),
        .active      (walk_active),
        .seg         (SEG_W'(seg_a)),
        .tbl_chain   (tbl_chain),
        .tbl_logical (tbl_logical),
        .cur         (walk_cur),
        .hit         (walk_hit),
        .chain_fault (walk_fault)
    );

    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        ld_write    = 1'b0;
        advance     = 1'b0;
        finish      = 1'b0;
        walk_load   = 1'b0;
        walk_active = 1'b0;
        tbl_index   = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = XLATE;
                end
            end
            XLATE: begin
                if (seg_a == '0) begin
                    if (phys_ok) begin
                        ld_write = 1'b1;
                        state_d  = WRITE;
                    end else begin
                        state_d = FAULT;
                    end
                end else begin
                    // Read the start segment's chain link to seed the walk.
                    tbl_index = start_q;
                    walk_load = 1'b1;
                    state_d   = WALK;
                end
            end
            WALK: begin
                tbl_index   = walk_cur;
                walk_active = 1'b1;
                if (walk_hit) begin
                    if (phys_ok) begin
                        ld_write = 1'b1;
                        state_d  = WRITE;
                    end else begin
                        state_d = FAULT;
                    end
                end else if (walk_fault) begin
                    state_d = FAULT;
                end
            end
            WRITE: begin
                if (two_q) begin
                    // Second byte is translated on its own; it may sit on another page.
                    advance = 1'b1;
                    state_d = XLATE;
                end else begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            FAULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            ram_addra <= '0;
            ram_dia   <= '0;
        end else begin
            state  <= state_d;
            done_q <= finish;
            if (ld_write) begin
                ram_addra <= phys[ADDR_W-1:0];
                ram_dia   <= byte_q;
            end
        end
    end

    // Request payload; only meaningful while a store is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            start_q <= start_segment;
            two_q   <= req_two;
            byte_q  <= req_two ? req_data[15:8] : req_data[7:0];
            byte2_q <= req_data[7:0];
        end else if (advance) begin
            addr_q <= addr_q + 1'b1;
            byte_q <= byte2_q;
            two_q  <= 1'b0;
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign ram_wea   = (state == WRITE);
    assign ram_ena   = (state == WRITE);
    assign fault     = (state == FAULT);
    assign done      = done_q;

endmodule

// File: tb/tb_stage3_ram_writer.sv
// Testbench for stage3_ram_writer: drives stores, models the MMU table and
// the expected translation/timing of every byte, and compares port A writes,
// done/fault pulses and handshake timing.
module tb_stage3_ram_writer;

    localparam int ADDR_W = 10;
    localparam int SEG_W  = 12;
    localparam int PAGE   = 151;
    localparam int MAXH   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_data;
    logic              req_two;
    logic [SEG_W-1:0]  start_segment;
    logic [SEG_W-1:0]  tbl_index;
    logic [SEG_W-1:0]  tbl_chain;
    logic [SEG_W-1:0]  tbl_logical;
    logic              ram_ena;
    logic              ram_wea;
    logic [ADDR_W-1:0] ram_addra;
    logic [7:0]        ram_dia;
    logic              busy;
    logic              done;
    logic              fault;

    logic [SEG_W-1:0] chain_mem [0:4095];
    logic [SEG_W-1:0] log_mem   [0:4095];

    int n_checks = 0;
    int n_pass   = 0;

    assign tbl_chain   = chain_mem[tbl_index];
    assign tbl_logical = log_mem[tbl_index];

    always #5 clk = ~clk;

    stage3_ram_writer dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_two       (req_two),
        .start_segment (start_segment),
        .tbl_index     (tbl_index),
        .tbl_chain     (tbl_chain),
        .tbl_logical   (tbl_logical),
        .ram_ena       (ram_ena),
        .ram_wea       (ram_wea),
        .ram_addra     (ram_addra),
        .ram_dia       (ram_dia),
        .busy          (busy),
        .done          (done),
        .fault         (fault)
    );

    task automatic clear_table();
        for (int k = 0; k < 4096; k++) begin
            chain_mem[k] = 12'(k);
            log_mem[k]   = 12'hFFF;
        end
    endtask

    task automatic load_spec_table();
        clear_table();
        chain_mem[0] = 12'd5; chain_mem[5] = 12'd2; chain_mem[2] = 12'd1; chain_mem[1] = 12'd1;
        log_mem[0] = 12'd0; log_mem[5] = 12'd3; log_mem[2] = 12'd2; log_mem[1] = 12'd1;
    endtask

    // Reference translation: returns physical address, number of walk cycles, success.
    task automatic model_xlate(input int a, input int ss, output int phys, output int walks, output bit ok);
        int seg, off, ps, cur, hops;
        bit found;
        seg = a / PAGE; off = a % PAGE;
        walks = 0; found = 0; ps = 0;
        if (seg == 0) begin
            ps = ss; found = 1;
        end else begin
            cur = int'(chain_mem[ss]); hops = 0;
            while (1) begin
                walks++;
                if (int'(log_mem[cur]) == seg) begin ps = cur; found = 1; break; end
                if (int'(chain_mem[cur]) == cur || hops == MAXH) break;
                cur = int'(chain_mem[cur]); hops++;
            end
        end
        phys = ps * PAGE + off;
        ok = found && (phys < (1 << ADDR_W));
    endtask

    task automatic run_store(input string name, input int a, input logic [15:0] d, input bit two, input int ss);
        int ew_i[2], ew_a[2], ew_d[2];
        int gw_i[4], gw_a[4], gw_d[4];
        int n_ew, e_fault, e_done, t, ba, ph, w;
        int n_gw, g_done, n_done, g_fault, n_fault, g_ready, n_ena_bad, nb;
        bit ok;
        n_ew = 0; e_fault = 0; e_done = 0; t = 0; ba = a;
        nb = two ? 2 : 1;
        for (int b = 0; b < nb; b++) begin
            model_xlate(ba, ss, ph, w, ok);
            t = t + 2 + w;
            if (!ok) begin e_fault = t; break; end
            ew_i[n_ew] = t; ew_a[n_ew] = ph;
            ew_d[n_ew] = (two && b == 0) ? int'(d[15:8]) : int'(d[7:0]);
            n_ew++;
            ba = (ba + 1) % (1 << ADDR_W);
        end
        if (e_fault == 0) e_done = t + 1;

        @(negedge clk);
        req_valid = 1'b1; req_addr = 10'(a); req_data = d; req_two = two; start_segment = 12'(ss);
        @(posedge clk);
        n_gw = 0; g_done = 0; n_done = 0; g_fault = 0; n_fault = 0; g_ready = 0; n_ena_bad = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            if (ram_wea === 1'b1) begin
                if (n_gw < 4) begin gw_i[n_gw] = i; gw_a[n_gw] = int'(ram_addra); gw_d[n_gw] = int'(ram_dia); end
                n_gw++;
            end
            if (ram_ena !== ram_wea) n_ena_bad++;
            if (done === 1'b1) begin if (n_done == 0) g_done = i; n_done++; end
            if (fault === 1'b1) begin if (n_fault == 0) g_fault = i; n_fault++; end
            if (req_ready === 1'b1) begin g_ready = i; break; end
        end

        n_checks++;
        if (g_ready == 0) $display("FAIL %s timeout: req_ready never returned within 80 cycles", name);
        else n_pass++;
        n_checks++;
        if (n_gw !== n_ew) $display("FAIL %s write_count: got %0d want %0d", name, n_gw, n_ew);
        else n_pass++;
        for (int k = 0; k < n_ew && k < n_gw; k++) begin
            n_checks++;
            if (gw_i[k] !== ew_i[k]) $display("FAIL %s write%0d cycle: got %0d want %0d", name, k, gw_i[k], ew_i[k]);
            else n_pass++;
            n_checks++;
            if (gw_a[k] !== ew_a[k]) $display("FAIL %s write%0d addra: got %0d want %0d", name, k, gw_a[k], ew_a[k]);
            else n_pass++;
            n_checks++;
            if (gw_d[k] !== ew_d[k]) $display("FAIL %s write%0d dia: got %0h want %0h", name, k, gw_d[k], ew_d[k]);
            else n_pass++;
        end
        n_checks++;
        if (g_done !== e_done || n_done !== (e_done != 0 ? 1 : 0))
            $display("FAIL %s done: got cycle %0d x%0d want cycle %0d", name, g_done, n_done, e_done);
        else n_pass++;
        n_checks++;
        if (g_fault !== e_fault || n_fault !== (e_fault != 0 ? 1 : 0))
            $display("FAIL %s fault: got cycle %0d x%0d want cycle %0d", name, g_fault, n_fault, e_fault);
        else n_pass++;
        n_checks++;
        if (g_ready !== t + 1) $display("FAIL %s ready_cycle: got %0d want %0d", name, g_ready, t + 1);
        else n_pass++;
        n_checks++;
        if (n_ena_bad !== 0) $display("FAIL %s ena_eq_wea: got %0d bad cycles want 0", name, n_ena_bad);
        else n_pass++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({req_ready, busy, done, fault, ram_ena, ram_wea} !== 6'b100000)
            $display("FAIL reset_flags: got %b want 100000", {req_ready, busy, done, fault, ram_ena, ram_wea});
        else n_pass++;
        n_checks++;
        if (ram_addra !== '0 || ram_dia !== '0 || tbl_index !== '0)
            $display("FAIL reset_data: got addra=%0d dia=%0h idx=%0d want 0", ram_addra, ram_dia, tbl_index);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release: got ready=%b busy=%b want 1 0", req_ready, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n_before, n_after;
        // Reset while the write strobe is high drops it at once.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 10'd10; req_data = 16'h0011; req_two = 1'b0; start_segment = '0;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ram_wea !== 1'b1) $display("FAIL rst_in_write_pre: got wea=%b want 1", ram_wea);
        else n_pass++;
        rst = 1'b0; #1;
        n_checks++;
        if (ram_wea !== 1'b0 || ram_ena !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL rst_in_write: got wea=%b ena=%b ready=%b want 0 0 1", ram_wea, ram_ena, req_ready);
        else n_pass++;
        @(negedge clk); rst = 1'b1;
        // Reset during the chain walk of byte 2 of a 2-byte store.
        n_before = 0; n_after = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 10'd150; req_data = 16'h1234; req_two = 1'b1; start_segment = '0;
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            if (ram_wea === 1'b1) n_before++;
        end
        n_checks++;
        if (busy !== 1'b1 || tbl_index !== 12'd2) $display("FAIL rst_walk_pre: got busy=%b idx=%0d want 1 2", busy, tbl_index);
        else n_pass++;
        rst = 1'b0; #1;
        n_checks++;
        if ({req_ready, busy, done, fault, ram_ena, ram_wea} !== 6'b100000)
            $display("FAIL rst_walk_flags: got %b want 100000", {req_ready, busy, done, fault, ram_ena, ram_wea});
        else n_pass++;
        n_checks++;
        if (ram_addra !== '0 || ram_dia !== '0 || tbl_index !== '0)
            $display("FAIL rst_walk_data: got addra=%0d dia=%0h idx=%0d want 0", ram_addra, ram_dia, tbl_index);
        else n_pass++;
        n_checks++;
        if (n_before !== 1) $display("FAIL rst_walk_byte1: got %0d writes want 1", n_before);
        else n_pass++;
        @(negedge clk); @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ram_wea === 1'b1 || done === 1'b1) n_after++;
        end
        n_checks++;
        if (n_after !== 0) $display("FAIL rst_walk_after: got %0d wea/done cycles want 0", n_after);
        else n_pass++;
        run_store("post_reset", 10, 16'h0077, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int w_i[4], w_a[4], w_d[4];
        int nw, d_i[4], nd;
        nw = 0; nd = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 10'd10; req_data = 16'h00C3; req_two = 1'b0; start_segment = '0;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin req_addr = 10'd20; req_data = 16'h005A; end
            if (ram_wea === 1'b1) begin
                if (nw < 4) begin w_i[nw] = i; w_a[nw] = int'(ram_addra); w_d[nw] = int'(ram_dia); end
                nw++;
            end
            if (done === 1'b1) begin if (nd < 4) d_i[nd] = i; nd++; end
            if (i == 4) req_valid = 1'b0;
        end
        n_checks++;
        if (nw !== 2 || nd !== 2) $display("FAIL b2b_counts: got writes=%0d dones=%0d want 2 2", nw, nd);
        else n_pass++;
        if (nw == 2 && nd == 2) begin
            n_checks++;
            if (w_i[0] !== 2 || w_a[0] !== 10 || w_d[0] !== 'hC3)
                $display("FAIL b2b_first: got cyc=%0d addr=%0d dia=%0h want 2 10 c3", w_i[0], w_a[0], w_d[0]);
            else n_pass++;
            n_checks++;
            if (w_i[1] !== 5 || w_a[1] !== 20 || w_d[1] !== 'h5A)
                $display("FAIL b2b_second: got cyc=%0d addr=%0d dia=%0h want 5 20 5a", w_i[1], w_a[1], w_d[1]);
            else n_pass++;
            n_checks++;
            if (d_i[0] !== 3 || d_i[1] !== 6) $display("FAIL b2b_done: got %0d,%0d want 3,6", d_i[0], d_i[1]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int a, ss;
        logic [15:0] d;
        bit two;
        for (int n = 0; n < 40; n++) begin
            clear_table();
            for (int k = 0; k < 8; k++) begin
                chain_mem[k] = 12'($urandom_range(0, 7));
                log_mem[k]   = 12'($urandom_range(0, 7));
            end
            a   = int'($urandom_range(0, 1023));
            ss  = int'($urandom_range(0, 7));
            d   = 16'($urandom);
            two = 1'($urandom);
            run_store("random", a, d, two, ss);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_addr = '0; req_data = '0; req_two = 1'b0; start_segment = '0;
        load_spec_table();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();

        // Main store paths on the reference table.
        run_store("single_seg0", 10, 16'h00AB, 1'b0, 0);
        run_store("two_byte_walk", 150, 16'h1234, 1'b1, 0);
        run_store("walk_hop0", 453, 16'h00E7, 1'b0, 0);
        run_store("chain_end_fault", 604, 16'h0099, 1'b0, 0);
        run_store("byte2_fault", 603, 16'hBEEF, 1'b1, 0);
        run_store("phys_out_of_range", 150, 16'h0042, 1'b0, 7);

        // Byte 2 address wraps to 0 after a walked byte 1.
        clear_table();
        chain_mem[0] = 12'd3; log_mem[3] = 12'd6;
        run_store("addr_wrap", 1023, 16'hA55A, 1'b1, 0);

        // Hit exactly at the hop limit, and one page further faults there.
        clear_table();
        chain_mem[0] = 12'd20;
        for (int k = 20; k < 35; k++) chain_mem[k] = 12'(k + 1);
        chain_mem[35] = 12'd2; log_mem[2] = 12'd2; chain_mem[2] = 12'd40; log_mem[40] = 12'd9;
        run_store("hop_limit_hit", 302, 16'h0066, 1'b0, 0);
        run_store("hop_limit_fault", 453, 16'h0066, 1'b0, 0);

        load_spec_table();
        test_reset_mid();
        test_back_to_back();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
